// File: rtl/table_sequencer_if.sv
// Register bus between the host and the table sequencer.
// Word-addressed, Avalon-style strobes with registered read data.
interface table_sequencer_if;
    logic [15:0] address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output writedata,
        output write,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  writedata,
        input  write,
        input  read,
        output readdata
    );
endinterface

// File: rtl/table_sequencer.sv
// Host-loaded (x, i, fi) table played back with a programmable dwell per entry.
// Drives the table-mode inputs of the settings mux.
module table_sequencer #(
    parameter int WIDTH_SET = 16,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int DWELL_W   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    table_sequencer_if.slave       bus,
    input  logic                   start_table,
    output logic [2*WIDTH_SET-1:0] x_table,
    output logic [2*WIDTH_SET-1:0] i_table,
    output logic [2*WIDTH_SET-1:0] fi_table,
    output logic                   table_valid,
    output logic                   step,
    output logic                   busy,
    output logic                   done
);

    localparam int FW = 2 * WIDTH_SET;
    localparam logic [15:0] TAB_BASE = 16'h1000;
    localparam logic [16:0] TAB_SPAN = 17'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [FW-1:0] x_mem  [DEPTH];
    logic [FW-1:0] i_mem  [DEPTH];
    logic [FW-1:0] fi_mem [DEPTH];

    logic               loop_q;
    logic [ADDR_W:0]    len_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               len_err_q;
    logic               wr_err_q;
    logic               addr_err_q;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               fresh_q, fresh_d;
    logic               start_q;
    logic               len_err_set;

    logic [15:0]        off;
    logic               tab_hit;
    logic [ADDR_W-1:0]  tab_n;
    logic [1:0]         tab_f;
    logic               ctrl_hit, len_hit, dwell_hit, stat_hit, bad_addr;
    logic               wr, rd, running, locked_wr;
    logic [DWELL_W-1:0] wr_dwell;
    logic [31:0]        rd_val;
    logic               unused_off;

    // Bus decode
    assign off       = bus.address - TAB_BASE;
    assign tab_hit   = (bus.address >= TAB_BASE) && ({1'b0, off} < TAB_SPAN);
    assign tab_n     = off[ADDR_W+1:2];
    assign tab_f     = off[1:0];
    assign ctrl_hit  = bus.address == 16'h0000;
    assign len_hit   = bus.address == 16'h0001;
    assign dwell_hit = bus.address == 16'h0002;
    assign stat_hit  = bus.address == 16'h0003;
    assign bad_addr  = !(ctrl_hit || len_hit || dwell_hit || stat_hit || tab_hit);
    assign wr        = bus.write;
    assign rd        = bus.read && !bus.write;
    assign running   = state_q == RUN;
    assign locked_wr = wr && running && (len_hit || dwell_hit || tab_hit);
    assign wr_dwell  = bus.writedata[DWELL_W-1:0];
    assign unused_off = ^off[15:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            loop_q     <= 1'b0;
            len_q      <= '0;
            dwell_q    <= DWELL_W'(1);
            len_err_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (wr && ctrl_hit) begin
                loop_q <= bus.writedata[0];
                if (bus.writedata[1]) begin
                    len_err_q  <= 1'b0;
                    wr_err_q   <= 1'b0;
                    addr_err_q <= 1'b0;
                end
            end
            if (locked_wr) begin
                wr_err_q <= 1'b1;
            end else begin
                if (wr && len_hit)
                    len_q <= (bus.writedata > 32'(DEPTH)) ?
                             (ADDR_W+1)'(DEPTH) :
                             bus.writedata[ADDR_W:0];
                if (wr && dwell_hit)
                    dwell_q <= (wr_dwell == '0) ? DWELL_W'(1) : wr_dwell;
            end
            if (wr && bad_addr)
                addr_err_q <= 1'b1;
            if (len_err_set)
                len_err_q <= 1'b1;
        end
    end

    // Table storage is not reset
    always_ff @(posedge clk) begin
        if (wr && tab_hit && !running) begin
            unique case (tab_f)
                2'd0:    x_mem[tab_n]  <= bus.writedata[FW-1:0];
                2'd1:    i_mem[tab_n]  <= bus.writedata[FW-1:0];
                2'd2:    fi_mem[tab_n] <= bus.writedata[FW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            ctrl_hit:  rd_val = {31'b0, loop_q};
            len_hit:   rd_val = 32'(len_q);
            dwell_hit: rd_val = 32'(dwell_q);
            stat_hit:  rd_val = {8'b0, 8'(idx_q), 11'b0,
                                 addr_err_q, wr_err_q, len_err_q,
                                 done, busy};
            tab_hit: begin
                unique case (tab_f)
                    2'd0:    rd_val = 32'(x_mem[tab_n]);
                    2'd1:    rd_val = 32'(i_mem[tab_n]);
                    2'd2:    rd_val = 32'(fi_mem[tab_n]);
                    default: rd_val = '0;
                endcase
            end
            default:   rd_val = '0;
        endcase
    end

    // Simultaneous write+read leaves readdata untouched
    always_ff @(posedge clk) begin
        if (rst)
            bus.readdata <= '0;
        else if (rd)
            bus.readdata <= rd_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            fresh_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
            start_q <= start_table;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fresh_d     = 1'b0;
        len_err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_table && len_q == '0) begin
                    len_err_set = 1'b1;
                end else if (start_table && !start_q) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = dwell_q - DWELL_W'(1);
                    fresh_d = 1'b1;
                end
            end
            RUN: begin
                if (!start_table) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if ({1'b0, idx_q} != len_q - (ADDR_W+1)'(1)) begin
                    idx_d   = idx_q + ADDR_W'(1);
                    cnt_d   = dwell_q - DWELL_W'(1);
                    fresh_d = 1'b1;
                end else if (loop_q) begin
                    idx_d   = '0;
                    cnt_d   = dwell_q - DWELL_W'(1);
                    fresh_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start_table)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs lag idx by one cycle; DONE keeps showing the last entry
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            x_table     <= '0;
            i_table     <= '0;
            fi_table    <= '0;
            table_valid <= 1'b0;
            step        <= 1'b0;
        end else begin
            x_table     <= x_mem[idx_q];
            i_table     <= i_mem[idx_q];
            fi_table    <= fi_mem[idx_q];
            table_valid <= 1'b1;
            step        <= running && fresh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= state_q == RUN;
            done <= state_q == DONE;
        end
    end

endmodule

// File: tb/tb_table_sequencer.sv
// Directed bench for table_sequencer: register map, playback timing,
// looping, error flags, abort and mid-run reset.
module tb_table_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_table;
    logic [31:0] x_table, i_table, fi_table;
    logic        table_valid, step, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    table_sequencer_if bus ();

    table_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .start_table (start_table),
        .x_table     (x_table),
        .i_table     (i_table),
        .fi_table    (fi_table),
        .table_valid (table_valid),
        .step        (step),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_vec_t;

    typedef struct {
        logic [31:0] x, i, fi;
        logic        st, vl, bs, dn;
    } seq_vec_t;

    bus_vec_t bv[$];
    seq_vec_t sv[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
        d           = bus.readdata;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_x"},     x_table, 32'h0);
        check({tag, "_valid"}, 32'(table_valid), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] loop_x [3];

        bv.push_back('{1'b1, 16'h0002, 32'h0});
        bv.push_back('{1'b0, 16'h0002, 32'h1});
        bv.push_back('{1'b1, 16'h0001, 32'd100});
        bv.push_back('{1'b0, 16'h0001, 32'd64});
        bv.push_back('{1'b1, 16'h0001, 32'd3});
        bv.push_back('{1'b0, 16'h0001, 32'd3});
        bv.push_back('{1'b1, 16'h0002, 32'd4});
        bv.push_back('{1'b0, 16'h0002, 32'd4});
        bv.push_back('{1'b1, 16'h1000, 32'h11});
        bv.push_back('{1'b1, 16'h1001, 32'hA1});
        bv.push_back('{1'b1, 16'h1002, 32'hF1});
        bv.push_back('{1'b1, 16'h1004, 32'h22});
        bv.push_back('{1'b1, 16'h1005, 32'hA2});
        bv.push_back('{1'b1, 16'h1006, 32'hF2});
        bv.push_back('{1'b1, 16'h1008, 32'h33});
        bv.push_back('{1'b1, 16'h1009, 32'hA3});
        bv.push_back('{1'b1, 16'h100A, 32'hF3});
        bv.push_back('{1'b1, 16'h1003, 32'hDEAD});
        bv.push_back('{1'b0, 16'h1000, 32'h11});
        bv.push_back('{1'b0, 16'h1005, 32'hA2});
        bv.push_back('{1'b0, 16'h100A, 32'hF3});
        bv.push_back('{1'b0, 16'h1003, 32'h0});
        bv.push_back('{1'b1, 16'h0000, 32'h0});
        bv.push_back('{1'b0, 16'h0000, 32'h0});
        bv.push_back('{1'b0, 16'h0003, 32'h0});

        // cycle k after start_table rises; LEN=3, DWELL=4, no loop
        sv[0]  = '{32'h00, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        sv[1]  = '{32'h00, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        sv[2]  = '{32'h11, 32'hA1, 32'hF1, 1'b1, 1'b1, 1'b1, 1'b0};
        sv[3]  = '{32'h11, 32'hA1, 32'hF1, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[4]  = '{32'h11, 32'hA1, 32'hF1, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[5]  = '{32'h11, 32'hA1, 32'hF1, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[6]  = '{32'h22, 32'hA2, 32'hF2, 1'b1, 1'b1, 1'b1, 1'b0};
        sv[7]  = '{32'h22, 32'hA2, 32'hF2, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[8]  = '{32'h22, 32'hA2, 32'hF2, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[9]  = '{32'h22, 32'hA2, 32'hF2, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[10] = '{32'h33, 32'hA3, 32'hF3, 1'b1, 1'b1, 1'b1, 1'b0};
        sv[11] = '{32'h33, 32'hA3, 32'hF3, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[12] = '{32'h33, 32'hA3, 32'hF3, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[13] = '{32'h33, 32'hA3, 32'hF3, 1'b0, 1'b1, 1'b1, 1'b0};
        sv[14] = '{32'h33, 32'hA3, 32'hF3, 1'b0, 1'b1, 1'b0, 1'b1};
        sv[15] = '{32'h33, 32'hA3, 32'hF3, 1'b0, 1'b1, 1'b0, 1'b1};
        sv[16] = '{32'h33, 32'hA3, 32'hF3, 1'b0, 1'b1, 1'b0, 1'b1};

        loop_x[0] = 32'h11;
        loop_x[1] = 32'h22;
        loop_x[2] = 32'h33;

        rst           = 1'b1;
        start_table   = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        tick();
        tick();

        check("rst_x",     x_table, 32'h0);
        check("rst_i",     i_table, 32'h0);
        check("rst_fi",    fi_table, 32'h0);
        check("rst_valid", 32'(table_valid), 32'h0);
        check("rst_step",  32'(step), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_rdata", bus.readdata, 32'h0);
        rst = 1'b0;
        tick();

        bus_rd(16'h0003, rd); check("rst_status", rd, 32'h0);
        bus_rd(16'h0001, rd); check("rst_len",    rd, 32'h0);
        bus_rd(16'h0002, rd); check("rst_dwell",  rd, 32'h1);
        bus_rd(16'h0000, rd); check("rst_ctrl",   rd, 32'h0);

        foreach (bv[k]) begin
            if (bv[k].wr) begin
                bus_wr(bv[k].addr, bv[k].data);
            end else begin
                bus_rd(bv[k].addr, rd);
                check($sformatf("bus_rd_%h_v%0d", bv[k].addr, k),
                      rd, bv[k].data);
            end
        end

        // single pass, DWELL=4
        start_table = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("seq_x_c%0d", k),    x_table, sv[k].x);
            check($sformatf("seq_i_c%0d", k),    i_table, sv[k].i);
            check($sformatf("seq_fi_c%0d", k),   fi_table, sv[k].fi);
            check($sformatf("seq_step_c%0d", k), 32'(step), 32'(sv[k].st));
            check($sformatf("seq_vld_c%0d", k),  32'(table_valid), 32'(sv[k].vl));
            check($sformatf("seq_busy_c%0d", k), 32'(busy), 32'(sv[k].bs));
            check($sformatf("seq_done_c%0d", k), 32'(done), 32'(sv[k].dn));
            tick();
        end
        start_table = 1'b0;
        tick();
        tick();
        check_idle_outputs("seq_stop");
        check("seq_stop_done", 32'(done), 32'h0);

        // looping, DWELL=1
        bus_wr(16'h0002, 32'h0);
        bus_wr(16'h0000, 32'h1);
        start_table = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("loop_x_%0d", k),    x_table, loop_x[k % 3]);
            check($sformatf("loop_step_%0d", k), 32'(step), 32'h1);
            check($sformatf("loop_busy_%0d", k), 32'(busy), 32'h1);
            tick();
        end
        start_table = 1'b0;
        tick();
        tick();
        check_idle_outputs("loop_stop");

        // LEN=0 start attempt
        bus_wr(16'h0000, 32'h0);
        bus_wr(16'h0001, 32'h0);
        start_table = 1'b1;
        tick();
        tick();
        tick();
        check_idle_outputs("len0");
        start_table = 1'b0;
        tick();
        bus_rd(16'h0003, rd); check("len0_err", 32'(rd[4:0]), 32'h04);
        bus_wr(16'h0000, 32'h2);
        bus_rd(16'h0003, rd); check("len0_clr", 32'(rd[4:0]), 32'h00);

        // blocked table write while running, then abort
        bus_wr(16'h0001, 32'd3);
        bus_wr(16'h0002, 32'd4);
        start_table = 1'b1;
        tick();
        tick();
        tick();
        bus_wr(16'h1001, 32'h55);
        bus_rd(16'h0003, rd); check("wrerr_status", 32'(rd[4:0]), 32'h09);
        check("wrerr_x", x_table, 32'h11);
        start_table = 1'b0;
        tick();
        tick();
        check_idle_outputs("abort");
        bus_rd(16'h1001, rd); check("wrerr_table", rd, 32'hA1);
        bus_wr(16'h0000, 32'h2);
        bus_rd(16'h0003, rd); check("wrerr_clr", 32'(rd[4:0]), 32'h00);

        // unmapped address
        bus_wr(16'h0004, 32'h1234);
        bus_rd(16'h0004, rd); check("bad_rd", rd, 32'h0);
        bus_rd(16'h0003, rd); check("bad_status", 32'(rd[4:0]), 32'h10);
        bus_wr(16'h0000, 32'h2);

        // write and read together: write wins, readdata holds
        bus_rd(16'h0002, rd); check("wr_rd_pre", rd, 32'd4);
        bus.address   = 16'h0001;
        bus.writedata = 32'd7;
        bus.write     = 1'b1;
        bus.read      = 1'b1;
        tick();
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        check("wr_rd_hold", bus.readdata, 32'd4);
        bus_rd(16'h0001, rd); check("wr_rd_len", rd, 32'd7);
        bus_wr(16'h0001, 32'd3);

        // reset in the middle of entry 1
        start_table = 1'b1;
        repeat (7) tick();
        check("mid_x", x_table, 32'h22);
        rst         = 1'b1;
        start_table = 1'b0;
        tick();
        check("mrst_x",     x_table, 32'h0);
        check("mrst_i",     i_table, 32'h0);
        check("mrst_fi",    fi_table, 32'h0);
        check("mrst_valid", 32'(table_valid), 32'h0);
        check("mrst_step",  32'(step), 32'h0);
        check("mrst_busy",  32'(busy), 32'h0);
        check("mrst_done",  32'(done), 32'h0);
        rst = 1'b0;
        tick();
        bus_rd(16'h0001, rd); check("mrst_len",    rd, 32'h0);
        bus_rd(16'h0002, rd); check("mrst_dwell",  rd, 32'h1);
        bus_rd(16'h0003, rd); check("mrst_status", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/table_sequencer.md
Name: table_sequencer

Overview:
- Produces the table-mode set values `x_table`, `i_table` and `fi_table` consumed by the settings block.
- Holds a host-loaded table of up to DEPTH entries (x, i, fi), written over the same Avalon-style register bus.
- While `start_table` is high, steps through entries 0..LEN-1, holding each for DWELL clock cycles, optionally looping.
- Sits directly upstream of the settings mux; that mux selects between these outputs and the point-mode registers.

Parameters:
- WIDTH_SET, 16, half-width of one set value; each table field is 2*WIDTH_SET bits (must be ≤ 32).
- DEPTH, 64, number of table entries (power of two).
- ADDR_W, 6, log2(DEPTH).
- DWELL_W, 24, width of the per-entry dwell count.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous, active-high reset.
- address, input, 16, bus word address.
- writedata, input, 32, bus write data.
- write, input, 1, bus write strobe.
- read, input, 1, bus read strobe.
- readdata, output, 32, bus read data; registered, valid 1 cycle after `read`.
- start_table, input, 1, run enable (set_reg[1] of the settings block); level-sensitive.
- x_table, output, 2*WIDTH_SET, current entry x field.
- i_table, output, 2*WIDTH_SET, current entry i field.
- fi_table, output, 2*WIDTH_SET, current entry fi field.
- table_valid, output, 1, high while the outputs carry a sequenced entry.
- step, output, 1, 1-cycle pulse on the first cycle of each new entry.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.

Behaviour:
- Reset: all outputs 0; readdata 0; state IDLE; CTRL=0, LEN=0, DWELL=1; error flags 0. Table contents are not reset.
- Address map:
  - 0x0000 CTRL (RW): bit0 = loop; writing 1 to bit1 clears the error flags (bit1 reads 0).
  - 0x0001 LEN (RW, ADDR_W+1 bits): valid range 0..DEPTH; a write > DEPTH saturates to DEPTH.
  - 0x0002 DWELL (RW, DWELL_W bits): a write of 0 stores 1.
  - 0x0003 STATUS (RO): bit0 busy, bit1 done, bit2 len_err, bit3 wr_err, bit4 addr_err, [23:16] current index.
  - 0x1000 + 4n + f, for n < DEPTH: table field; f=0 x, f=1 i, f=2 fi, f=3 reserved (reads 0, writes ignored). Writes take writedata[2*WIDTH_SET-1:0]; reads are zero-extended.
- Bus errors:
  - Any other address: write sets sticky addr_err; read returns 0.
  - If write and read are asserted together, write wins and readdata holds its previous value.
- Table memory is read asynchronously on the sequencer side, so entries follow back-to-back with no gap cycles.
- FSM states IDLE, RUN, DONE:
  - IDLE: outputs 0, table_valid=0. If start_table=1 and LEN=0: set sticky len_err and stay in IDLE. If start_table=1 and LEN>0: go to RUN with idx=0 and cnt=DWELL-1.
  - RUN: on each clock, if cnt>0 then cnt-1. Otherwise, if idx<LEN-1: idx+1 and cnt=DWELL-1. If idx=LEN-1 and loop=1: idx=0 and cnt=DWELL-1. If idx=LEN-1 and loop=0: go to DONE.
  - DONE: the last entry's values are held and table_valid stays 1.
- Output timing:
  - Outputs are registered and update the cycle after idx changes.
  - The first entry appears 2 cycles after the cycle start_table is first sampled high.
  - Each entry is held exactly DWELL cycles; step pulses on each entry's first output cycle.
- start_table=0 in RUN or DONE: return to IDLE next cycle; outputs and table_valid go to 0 the following cycle.
- Restart requires start_table to go low and then high again. start_table held high in DONE does nothing.
- Writes to LEN, DWELL or the table while busy=1 are ignored and set sticky wr_err. CTRL writes are always accepted; loop is re-sampled when idx=LEN-1 expires.
- rst asserted mid-run: IDLE next cycle; all outputs 0 on that edge.

Test Plan:
- Load 3 entries (x=0x11/0x22/0x33, i=0xA1/0xA2/0xA3, fi=0xF1/0xF2/0xF3), LEN=3, DWELL=4, loop=0, start_table=1 -> each entry is held 4 cycles; step pulses at cycles 2, 6, 10 after start; done=1 from cycle 14 with x_table=0x33 held.
- Same table with loop=1, DWELL=1 -> x_table sequence 0x11, 0x22, 0x33, 0x11, … changes every cycle with no gaps; busy stays 1.
- LEN=0, start_table=1 -> stays IDLE, table_valid=0, STATUS bit2=1; CTRL write of 0x2 -> STATUS bit2 reads 0.
- During RUN, write to 0x1001 -> table unchanged, STATUS bit3=1. Then drop start_table -> outputs 0 two cycles later, busy=0.
- Write DWELL=0 -> read back 1. Write LEN=100 -> read back 64. Read 0x0004 -> 0 with STATUS bit4=1.
- Assert rst in the middle of entry 1 -> next edge all outputs 0, state IDLE; LEN and DWELL reset to 0 and 1.
